// File: rtl/vec_reduce_add_pkg.sv
// Shared helpers for the vector reduction block.
package vec_reduce_add_pkg;

  // Index counter width; a one-element vector still needs a 1-bit counter.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vec_macros.svh
// Shared vector layout helpers: float element width, packed vector width, element select.
`ifndef VEC_MACROS_SVH
`define VEC_MACROS_SVH

`define VEC_FW(E, F)        (1 + (E) + (F))
`define VEC_WIDTH(N, E, F)  ((N) * `VEC_FW(E, F))
`define VEC_ELEM(V, I, FW)  V[(I) * (FW) +: (FW)]

`endif

// File: rtl/vec_reduce_add_float_add.sv
// Combinational float adder, round-to-nearest-even; subnormals flush to zero,
// overflow saturates to infinity, NaN/Inf inputs are not special-cased.
`include "vec_macros.svh"

module float_add
  import vec_reduce_add_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23,
  parameter int BIAS       = 127
) (
  input  logic [`VEC_FW(EXP_WIDTH, FRAC_WIDTH)-1:0] a,
  input  logic [`VEC_FW(EXP_WIDTH, FRAC_WIDTH)-1:0] b,
  output logic [`VEC_FW(EXP_WIDTH, FRAC_WIDTH)-1:0] sum
);
  localparam int FW = `VEC_FW(EXP_WIDTH, FRAC_WIDTH);
  localparam int M  = FRAC_WIDTH + 1;
  localparam int W  = M + 3;

  logic                 swap, sgn, eff_sub, stk, found;
  logic [EXP_WIDTH-1:0] eb, es, diff;
  logic [W-1:0]         mb, ms, ms_al, norm;
  logic [W:0]           raw;
  logic [M:0]           man_r;
  int                   lz, e;

  always_comb begin
    swap    = b[FW-2:0] > a[FW-2:0];
    sgn     = swap ? b[FW-1] : a[FW-1];
    eff_sub = a[FW-1] ^ b[FW-1];
    eb      = swap ? b[FW-2 -: EXP_WIDTH] : a[FW-2 -: EXP_WIDTH];
    es      = swap ? a[FW-2 -: EXP_WIDTH] : b[FW-2 -: EXP_WIDTH];
    mb      = (eb == '0) ? '0 : {1'b1, (swap ? b[FRAC_WIDTH-1:0] : a[FRAC_WIDTH-1:0]), 3'b000};
    ms      = (es == '0) ? '0 : {1'b1, (swap ? a[FRAC_WIDTH-1:0] : b[FRAC_WIDTH-1:0]), 3'b000};
    diff    = eb - es;

    // Bits shifted out of the smaller operand collapse into the sticky bit.
    stk = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i < int'(diff)) stk = stk | ms[i];
    end
    ms_al = (ms >> diff) | W'(stk);
    raw   = eff_sub ? ({1'b0, mb} - {1'b0, ms_al}) : ({1'b0, mb} + {1'b0, ms_al});

    e     = int'(eb);
    lz    = 0;
    found = 1'b0;
    norm  = '0;
    if (raw[W]) begin
      norm = raw[W:1] | W'(raw[0]);
      e    = e + 1;
    end else begin
      for (int i = W - 1; i >= 0; i--) begin
        if (!found) begin
          if (raw[i]) found = 1'b1;
          else        lz    = lz + 1;
        end
      end
      norm = raw[W-1:0] << lz;
      e    = e - lz;
    end

    man_r = {1'b0, norm[W-1:3]} + (M+1)'(norm[2] & (norm[3] | norm[1] | norm[0]));
    if (man_r[M]) e = e + 1;

    if (raw == '0)
      sum = '0;
    else if (e <= 0)
      sum = {sgn, {(FW-1){1'b0}}};
    else if (e > 2 * BIAS)
      sum = {sgn, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
    else
      sum = {sgn, e[EXP_WIDTH-1:0], (man_r[M] ? man_r[M-1:1] : man_r[M-2:0])};
  end

endmodule

// File: rtl/vec_reduce_add.sv
// Sequential left-to-right float sum of a packed vector through one shared adder.
// Latency VEC_SIZE cycles; in_ready only in IDLE, result held in DONE until out_ready.
`include "vec_macros.svh"

module vec_reduce_add
  import vec_reduce_add_pkg::*;
#(
  parameter int VEC_SIZE   = 4,
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23,
  parameter int BIAS       = 127
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  input  logic [`VEC_WIDTH(VEC_SIZE, EXP_WIDTH, FRAC_WIDTH)-1:0] in_vec,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic [`VEC_FW(EXP_WIDTH, FRAC_WIDTH)-1:0]              out_sum
);
  localparam int FW = `VEC_FW(EXP_WIDTH, FRAC_WIDTH);
  localparam int VW = `VEC_WIDTH(VEC_SIZE, EXP_WIDTH, FRAC_WIDTH);
  localparam int IW = idx_width(VEC_SIZE);
  localparam logic [IW-1:0] LAST = IW'(VEC_SIZE - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [FW-1:0] acc;
  logic [VW-1:0] vec_q;
  logic [FW-1:0] elem;
  logic [FW-1:0] add_sum;

  assign elem      = `VEC_ELEM(vec_q, idx, FW);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_sum   = acc;

  float_add #(
    .EXP_WIDTH (EXP_WIDTH),
    .FRAC_WIDTH(FRAC_WIDTH),
    .BIAS      (BIAS)
  ) u_add (
    .a  (acc),
    .b  (elem),
    .sum(add_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      acc   <= '0;
      vec_q <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          vec_q <= in_vec;
          acc   <= in_vec[FW-1:0];
          if (VEC_SIZE > 1) begin
            idx   <= IW'(1);
            state <= ACCUM;
          end else begin
            idx   <= '0;
            state <= DONE;
          end
        end
        ACCUM: begin
          acc <= add_sum;
          if (idx == LAST) begin
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_reduce_add.sv
// Directed bench for vec_reduce_add: a 4-element and a 1-element instance.
module tb_vec_reduce_add;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid4, in_ready4, out_valid4, out_ready4;
  logic [127:0] in_vec4;
  logic [31:0]  out_sum4;
  logic         in_valid1, in_ready1, out_valid1, out_ready1;
  logic [31:0]  in_vec1;
  logic [31:0]  out_sum1;

  int checks   = 0;
  int failures = 0;
  int n;

  localparam logic [127:0] V_1234 = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
  localparam logic [127:0] V_ONES = {4{32'h3F800000}};
  localparam logic [127:0] V_ALT  = {32'hBF800000, 32'h3F800000, 32'hBF800000, 32'h3F800000};
  localparam logic [127:0] V_TIE  = {32'h0, 32'h0, 32'h33800000, 32'h3F800000};
  localparam logic [127:0] V_UP   = {32'h0, 32'h0, 32'h33800001, 32'h3F800000};

  always #5 clk = ~clk;

  vec_reduce_add #(.VEC_SIZE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .in_vec(in_vec4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_sum(out_sum4)
  );

  vec_reduce_add #(.VEC_SIZE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .in_vec(in_vec1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one vector through the accept edge, then drop in_valid and scramble in_vec.
  task automatic send4(input logic [127:0] v);
    in_valid4 = 1'b1;
    in_vec4   = v;
    tick();
    in_valid4 = 1'b0;
    in_vec4   = {4{32'hDEADBEEF}};
  endtask

  // Cycles from the accept edge until out_valid, bounded.
  task automatic wait_valid4(output int cnt);
    cnt = 0;
    while (out_valid4 !== 1'b1 && cnt < 16) begin
      tick();
      cnt++;
    end
  endtask

  task automatic run4(input string tag, input logic [127:0] v, input logic [31:0] exp);
    int c;
    send4(v);
    wait_valid4(c);
    chk({tag, "_lat"}, c, 3);
    chk({tag, "_sum"}, out_sum4, exp);
    tick();
    chk({tag, "_idle"}, in_ready4, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid4 = 1'b0; in_vec4 = '0; out_ready4 = 1'b1;
    in_valid1 = 1'b0; in_vec1 = '0; out_ready1 = 1'b1;
    repeat (2) tick();
    chk("rst_in_ready4", in_ready4, 1);
    chk("rst_out_valid4", out_valid4, 0);
    chk("rst_out_sum4", out_sum4, 32'h0);
    chk("rst_in_ready1", in_ready1, 1);
    chk("rst_out_sum1", out_sum1, 32'h0);

    // Accept on the first edge after reset release.
    rst_n = 1'b1;
    send4(V_1234);
    chk("busy_after_accept", in_ready4, 0);
    chk("no_early_valid", out_valid4, 0);
    wait_valid4(n);
    chk("lat_1234", n, 3);
    chk("sum_1234", out_sum4, 32'h41200000);
    tick();
    chk("idle_after_1234", in_ready4, 1);
    chk("valid_drop_1234", out_valid4, 0);

    // Backpressure: result held for 5 cycles.
    out_ready4 = 1'b0;
    send4(V_1234);
    wait_valid4(n);
    chk("lat_hold", n, 3);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", out_valid4, 1);
      chk("hold_sum", out_sum4, 32'h41200000);
      chk("hold_in_ready", in_ready4, 0);
      tick();
    end
    out_ready4 = 1'b1;
    tick();
    chk("hold_release_idle", in_ready4, 1);
    chk("hold_release_valid", out_valid4, 0);

    // Reset two cycles into accumulation discards the vector.
    send4(V_1234);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid4, 0);
    chk("midrst_in_ready", in_ready4, 1);
    chk("midrst_out_sum", out_sum4, 32'h0);
    tick();
    rst_n = 1'b1;
    chk("midrst_no_stale", out_valid4, 0);
    run4("ones", V_ONES, 32'h40800000);

    // Input churn during ACCUM and in_valid held through DONE.
    out_ready4 = 1'b0;
    in_valid4  = 1'b1;
    in_vec4    = V_1234;
    tick();
    for (int i = 0; i < 3; i++) begin
      in_vec4 = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    chk("churn_valid", out_valid4, 1);
    chk("churn_sum", out_sum4, 32'h41200000);
    for (int i = 0; i < 3; i++) begin
      in_vec4 = {4{32'h3F800000}};
      tick();
      chk("churn_no_accept", in_ready4, 0);
      chk("churn_sum_stable", out_sum4, 32'h41200000);
    end
    in_valid4  = 1'b0;
    out_ready4 = 1'b1;
    tick();
    chk("churn_idle", in_ready4, 1);
    tick();
    chk("churn_no_second", out_valid4, 0);

    // Zero results and rounding boundaries.
    run4("zeros", '0, 32'h00000000);
    run4("cancel", V_ALT, 32'h00000000);
    run4("tie_even", V_TIE, 32'h3F800000);
    run4("round_up", V_UP, 32'h3F800001);

    // Single-element instance: result one cycle after accept.
    in_valid1 = 1'b1;
    in_vec1   = 32'h40400000;
    tick();
    in_valid1 = 1'b0;
    in_vec1   = 32'h0;
    chk("v1_valid", out_valid1, 1);
    chk("v1_sum", out_sum1, 32'h40400000);
    tick();
    chk("v1_idle", in_ready1, 1);
    chk("v1_valid_drop", out_valid1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
